// File: rtl/alu_flag_stage.sv
// alu_flag_stage: CPSR flag register, ARM condition evaluation and EX/MEM result slot.
// The S-update overrides an MSR in the same cycle, but only for the fields that the S-update writes.
module alu_flag_stage #(
  parameter int         DATA_W    = 32,
  parameter int         RD_W      = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_cond,
  input  logic              ex_s,
  input  logic              ex_logic,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              msr_we,
  input  logic [3:0]        msr_flags,
  input  logic              stall,
  input  logic              flush,
  output logic              cond_pass,
  output logic              alu_cin,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [RD_W-1:0]   mem_rd
);
  logic [3:0]        r_flags;
  logic              r_mem_valid;
  logic [DATA_W-1:0] r_mem_result;
  logic [RD_W-1:0]   r_mem_rd;
  logic              w_n, w_z, w_c, w_v;
  logic              w_commit, w_s_upd, w_cc_upd;
  logic [3:0]        w_base, w_next;
  assign {w_n, w_z, w_c, w_v} = r_flags;
  always_comb begin
    cond_pass = 1'b0;
    case (ex_cond)
      4'd0:    cond_pass = w_z;
      4'd1:    cond_pass = ~w_z;
      4'd2:    cond_pass = w_c;
      4'd3:    cond_pass = ~w_c;
      4'd4:    cond_pass = w_n;
      4'd5:    cond_pass = ~w_n;
      4'd6:    cond_pass = w_v;
      4'd7:    cond_pass = ~w_v;
      4'd8:    cond_pass = w_c & ~w_z;
      4'd9:    cond_pass = ~w_c | w_z;
      4'd10:   cond_pass = w_n == w_v;
      4'd11:   cond_pass = w_n != w_v;
      4'd12:   cond_pass = ~w_z & (w_n == w_v);
      4'd13:   cond_pass = w_z | (w_n != w_v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
  assign w_commit = ex_valid & cond_pass & ~stall & ~flush;
  assign w_s_upd  = w_commit & ex_s;
  assign w_cc_upd = w_s_upd & ~ex_logic;
  assign w_base   = (msr_we & ~stall) ? msr_flags : r_flags;
  assign w_next   = {w_s_upd  ? alu_n : w_base[3],
                     w_s_upd  ? alu_z : w_base[2],
                     w_cc_upd ? alu_c : w_base[1],
                     w_cc_upd ? alu_v : w_base[0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags      <= FLAGS_RST;
      r_mem_valid  <= 1'b0;
      r_mem_result <= '0;
      r_mem_rd     <= '0;
    end else begin
      r_flags <= w_next;
      if (flush | ~stall) r_mem_valid <= w_commit;
      if (w_commit) begin
        r_mem_result <= alu_o;
        r_mem_rd     <= ex_rd;
      end
    end
  end
  assign {flag_n, flag_z, flag_c, flag_v} = r_flags;
  assign alu_cin    = r_flags[1];
  assign mem_valid  = r_mem_valid;
  assign mem_result = r_mem_result;
  assign mem_rd     = r_mem_rd;
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: directed and random checks of alu_flag_stage against a flag/MEM-slot reference model.
module tb_alu_flag_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_s, ex_logic, msr_we, stall, flush;
  logic [3:0]  ex_cond, ex_rd, msr_flags;
  logic [31:0] alu_o;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        cond_pass, alu_cin, flag_n, flag_z, flag_c, flag_v, mem_valid;
  logic [31:0] mem_result;
  logic [3:0]  mem_rd;
  int          errors = 0;
  int          checks = 0;
  logic        en, ez, ec, ev, m_valid;
  logic [31:0] m_res;
  logic [3:0]  m_rd;

  alu_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_s(ex_s),
    .ex_logic(ex_logic), .ex_rd(ex_rd), .alu_o(alu_o), .alu_n(alu_n), .alu_z(alu_z),
    .alu_c(alu_c), .alu_v(alu_v), .msr_we(msr_we), .msr_flags(msr_flags), .stall(stall),
    .flush(flush), .cond_pass(cond_pass), .alu_cin(alu_cin), .flag_n(flag_n),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .mem_valid(mem_valid),
    .mem_result(mem_result), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // ARM encoding: even codes test a base predicate, the odd partner is its inverse.
  function automatic logic ref_cond(input logic [3:0] cc, input logic n, z, c, v);
    logic r;
    case (cc[3:1])
      3'd0:    r = z;
      3'd1:    r = c;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = c && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return r ^ cc[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    {en, ez, ec, ev} = 4'b0000;
    m_valid = 1'b0;
    m_res = '0;
    m_rd = '0;
  endtask

  task automatic idle();
    ex_valid = 0; ex_cond = 4'd14; ex_s = 0; ex_logic = 0; ex_rd = 0; alu_o = 0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    msr_we = 0; msr_flags = 0; stall = 0; flush = 0;
  endtask

  task automatic ex(input logic [3:0] cc, input logic s, input logic lg, input logic [3:0] nzcv,
                    input logic [31:0] res, input logic [3:0] rd);
    idle();
    ex_valid = 1; ex_cond = cc; ex_s = s; ex_logic = lg; alu_o = res; ex_rd = rd;
    {alu_n, alu_z, alu_c, alu_v} = nzcv;
  endtask

  task automatic tick();
    logic com;
    #1;
    chk("cond_pass", {31'b0, cond_pass}, {31'b0, ref_cond(ex_cond, en, ez, ec, ev)});
    com = ex_valid && ref_cond(ex_cond, en, ez, ec, ev) && !stall && !flush;
    if (!stall) begin
      if (msr_we) {en, ez, ec, ev} = msr_flags;
      if (com && ex_s) begin
        en = alu_n; ez = alu_z;
        if (!ex_logic) begin ec = alu_c; ev = alu_v; end
      end
    end
    if (flush) m_valid = 1'b0;
    else if (!stall) begin
      m_valid = com;
      if (com) begin m_res = alu_o; m_rd = ex_rd; end
    end
    @(posedge clk);
    #1;
    chk("flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, {28'b0, en, ez, ec, ev});
    chk("alu_cin", {31'b0, alu_cin}, {31'b0, ec});
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, m_valid});
    chk("mem_result", mem_result, m_res);
    chk("mem_rd", {28'b0, mem_rd}, {28'b0, m_rd});
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #12;
    chk("rst_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'h0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_mem_result", mem_result, 32'h0);
    chk("rst_mem_rd", {28'b0, mem_rd}, 32'h0);
    rst_n = 1;
    @(posedge clk);
    #1;
    // SUBS 5-5 then EQ / NE
    ex(4'd14, 1, 0, 4'b0110, 32'h0, 4'd1);
    tick();
    chk("subs_z", {31'b0, flag_z}, 32'h1);
    chk("subs_c", {31'b0, flag_c}, 32'h1);
    ex(4'd0, 0, 0, 4'b0000, 32'h11, 4'd2);
    #1 chk("eq_pass", {31'b0, cond_pass}, 32'h1);
    tick();
    ex(4'd1, 0, 0, 4'b0000, 32'h22, 4'd2);
    #1 chk("ne_fail", {31'b0, cond_pass}, 32'h0);
    tick();
    chk("ne_mem_valid", {31'b0, mem_valid}, 32'h0);
    // logical S-op keeps C and V
    idle(); msr_we = 1; msr_flags = 4'b0011;
    tick();
    ex(4'd14, 1, 1, 4'b1000, 32'h8000_0000, 4'd4);
    tick();
    chk("logic_nzcv", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'hB);
    // signed compares with N=1, V=0
    idle(); msr_we = 1; msr_flags = 4'b1000;
    tick();
    idle();
    ex_cond = 4'd11; #1 chk("lt_pass", {31'b0, cond_pass}, 32'h1);
    ex_cond = 4'd10; #1 chk("ge_fail", {31'b0, cond_pass}, 32'h0);
    ex_cond = 4'd12; #1 chk("gt_fail", {31'b0, cond_pass}, 32'h0);
    ex_cond = 4'd13; #1 chk("le_pass", {31'b0, cond_pass}, 32'h1);
    ex_cond = 4'd15; #1 chk("nv_fail", {31'b0, cond_pass}, 32'h0);
    ex_cond = 4'd14; #1 chk("al_pass", {31'b0, cond_pass}, 32'h1);
    tick();
    // stall holds MEM slot, flush with stall kills it
    ex(4'd14, 0, 0, 4'b0000, 32'h0000_00FF, 4'd3);
    tick();
    for (int i = 0; i < 2; i++) begin
      ex(4'd14, 1, 0, 4'b0101, 32'hDEAD_0000 + i, 4'd7);
      stall = 1;
      tick();
      chk("stall_result", mem_result, 32'h0000_00FF);
      chk("stall_rd", {28'b0, mem_rd}, 32'h3);
    end
    ex(4'd14, 1, 0, 4'b0101, 32'h1234, 4'd9);
    stall = 1; flush = 1;
    tick();
    chk("flush_valid", {31'b0, mem_valid}, 32'h0);
    chk("flush_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'h8);
    // MSR collides with S-update
    ex(4'd14, 1, 0, 4'b0101, 32'h5, 4'd5);
    msr_we = 1; msr_flags = 4'b1010;
    tick();
    chk("msr_adds", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'h5);
    ex(4'd14, 1, 1, 4'b0101, 32'h6, 4'd6);
    msr_we = 1; msr_flags = 4'b1010;
    tick();
    chk("msr_logic", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'h6);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      ex_valid  = ($urandom_range(3) != 0);
      ex_cond   = 4'($urandom);
      ex_s      = 1'($urandom);
      ex_logic  = 1'($urandom);
      ex_rd     = 4'($urandom);
      alu_o     = $urandom;
      {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
      msr_we    = ($urandom_range(4) == 0);
      msr_flags = 4'($urandom);
      stall     = ($urandom_range(3) == 0);
      flush     = ($urandom_range(7) == 0);
      tick();
    end
    // asynchronous reset mid-cycle with flags set and a valid MEM slot
    ex(4'd14, 0, 0, 4'b0000, 32'hCAFE, 4'd8);
    msr_we = 1; msr_flags = 4'b1111;
    tick();
    chk("pre_rst_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'hF);
    idle();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'h0);
    chk("async_rst_valid", {31'b0, mem_valid}, 32'h0);
    chk("async_rst_result", mem_result, 32'h0);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    ex(4'd2, 1, 0, 4'b1111, 32'h77, 4'd1);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
